// File: rtl/keypad_pkg.sv
// Shared types and key decode tables for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [2:0] SIGN_NONE = 3'b000;
    localparam logic [2:0] SIGN_MUL  = 3'b001;
    localparam logic [2:0] SIGN_ADD  = 3'b010;
    localparam logic [2:0] SIGN_SUB  = 3'b011;
    localparam logic [2:0] SIGN_CLR  = 3'b100;
    localparam logic [2:0] SIGN_D    = 3'b101;
    localparam logic [2:0] SIGN_EQ   = 3'b111;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Layout [row][col]: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code_lut(input logic [3:0] row_col);
        logic [3:0] code;
        case (row_col)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] sign_class(input logic [3:0] code);
        logic [2:0] cls;
        case (code)
            4'hA:    cls = SIGN_ADD;
            4'hB:    cls = SIGN_SUB;
            4'hC:    cls = SIGN_CLR;
            4'hD:    cls = SIGN_D;
            4'hE:    cls = SIGN_MUL;
            4'hF:    cls = SIGN_EQ;
            default: cls = SIGN_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        logic [3:0] drv;
        drv      = 4'b1111;
        drv[col] = 1'b0;
        return drv;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_row
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Reset to idle-high so no phantom press is seen coming out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= ROWS_IDLE;
            r_sync <= ROWS_IDLE;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner, press/release debouncer and key decoder feeding the
// calculator input-control FSM.
//
// state    | meaning
// SCAN     | drive one column per slot, sample rows at end of slot
// DEBOUNCE | column frozen, count consecutive low cycles of captured row
// HELD     | key accepted, key_pressed high, wait for row to go high
// RELEASE  | count consecutive high cycles; any low restarts the count
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_pressed,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [2:0] is_sign_key
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    state_t            r_state;
    logic [1:0]        r_col;
    logic [3:0]        r_col_o;
    logic [1:0]        r_row;
    logic [SLOT_W-1:0] r_slot;
    logic [DEB_W-1:0]  r_cnt;
    logic              r_key_pressed;
    logic              r_key_valid;
    logic [3:0]        r_key_code;
    logic [2:0]        r_sign;

    logic [3:0] w_rs;
    logic       w_any_low;
    logic [1:0] w_first_row;
    logic       w_row_bit;
    logic [1:0] w_next_col;
    logic [3:0] w_code;

    keypad_row_sync u_row_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_row   (row_i),
        .o_row   (w_rs)
    );

    assign w_any_low  = ~&w_rs;
    assign w_row_bit  = w_rs[r_row];
    assign w_next_col = r_col + 2'd1;
    assign w_code     = key_code_lut({r_row, r_col});

    // Lowest-numbered low row wins when several rows are active.
    always_comb begin
        w_first_row = 2'd0;
        if (!w_rs[0])      w_first_row = 2'd0;
        else if (!w_rs[1]) w_first_row = 2'd1;
        else if (!w_rs[2]) w_first_row = 2'd2;
        else if (!w_rs[3]) w_first_row = 2'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= SCAN;
            r_col         <= 2'd0;
            r_col_o       <= 4'b1110;
            r_row         <= 2'd0;
            r_slot        <= '0;
            r_cnt         <= '0;
            r_key_pressed <= 1'b0;
            r_key_valid   <= 1'b0;
            r_key_code    <= 4'h0;
            r_sign        <= SIGN_NONE;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_slot == SLOT_LAST) begin
                        r_slot <= '0;
                        if (w_any_low) begin
                            r_row   <= w_first_row;
                            r_cnt   <= '0;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col   <= w_next_col;
                            r_col_o <= col_drive(w_next_col);
                        end
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_row_bit) begin
                        r_state <= SCAN;
                        r_slot  <= '0;
                        r_col   <= w_next_col;
                        r_col_o <= col_drive(w_next_col);
                    end else if (r_cnt == DEB_LAST) begin
                        r_key_code    <= w_code;
                        r_sign        <= sign_class(w_code);
                        r_key_pressed <= 1'b1;
                        r_key_valid   <= 1'b1;
                        r_state       <= HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_row_bit) begin
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_row_bit) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_key_pressed <= 1'b0;
                        r_state       <= SCAN;
                        r_slot        <= '0;
                        r_col         <= w_next_col;
                        r_col_o       <= col_drive(w_next_col);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_o       = r_col_o;
    assign key_pressed = r_key_pressed;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign is_sign_key = r_sign;

endmodule
